// File: rtl/sprite_gpu_pkg.sv
// Shared sprite GPU definitions: widths, opcodes, command-word field positions and FSM encoding.
// Used by the write controller, its decoder and the print-module bench.
package sprite_gpu_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned MEM_ADDR_W  = 14;
    localparam int unsigned COLOR_W     = 9;
    localparam int unsigned X_W         = 10;
    localparam int unsigned Y_W         = 10;
    localparam int unsigned OFFSET_W    = 9;
    localparam int unsigned OPCODE_W    = 4;
    localparam int unsigned CMD_W       = 64;
    localparam int unsigned REG_DATA_W  = 32;

    localparam logic [OPCODE_W-1:0] OP_WBR = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_WSM = 4'b0001;

    // Command-word field LSB positions; bits at and above CMD_USED_W carry nothing.
    localparam int unsigned CMD_OP_LSB    = 0;
    localparam int unsigned CMD_IDX_LSB   = 4;
    localparam int unsigned CMD_SP_BIT    = 9;
    localparam int unsigned CMD_X_LSB     = 10;
    localparam int unsigned CMD_Y_LSB     = 20;
    localparam int unsigned CMD_OFF_LSB   = 30;
    localparam int unsigned CMD_ADDR_LSB  = 4;
    localparam int unsigned CMD_COLOR_LSB = 18;
    localparam int unsigned CMD_USED_W    = 39;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT_BLANK,
        ST_WRITE_REG,
        ST_WRITE_MEM
    } state_t;

    typedef enum logic [1:0] {
        KIND_WBR,
        KIND_WSM,
        KIND_BAD
    } cmd_kind_t;

    typedef struct packed {
        cmd_kind_t               kind;
        logic [REG_ADDR_W-1:0]   reg_idx;
        logic                    sp;
        logic [X_W-1:0]          x;
        logic [Y_W-1:0]          y;
        logic [OFFSET_W-1:0]     offset;
        logic [MEM_ADDR_W-1:0]   mem_addr;
        logic [COLOR_W-1:0]      color;
    } cmd_fields_t;

    // data_reg layout: [29] sp, [28:19] x, [18:9] y, [8:0] offset.
    function automatic logic [REG_DATA_W-1:0] pack_reg_data(input cmd_fields_t f);
        return {2'b00, f.sp, f.x, f.y, f.offset};
    endfunction

endpackage

// File: rtl/sprite_write_controller_if.sv
// Command handshake plus register-bank and sprite-memory write ports of the sprite write controller.
interface sprite_write_controller_if;
    import sprite_gpu_pkg::*;

    logic                    cmd_valid;
    logic [CMD_W-1:0]        cmd_word;
    logic                    cmd_ready;
    logic                    reg_wr_en;
    logic [REG_ADDR_W-1:0]   reg_wr_addr;
    logic [REG_DATA_W-1:0]   reg_wr_data;
    logic                    mem_wr_en;
    logic [MEM_ADDR_W-1:0]   mem_wr_addr;
    logic [COLOR_W-1:0]      mem_wr_data;

    modport master (
        output cmd_valid, cmd_word,
        input  cmd_ready,
        input  reg_wr_en, reg_wr_addr, reg_wr_data,
        input  mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  cmd_valid, cmd_word,
        output cmd_ready,
        output reg_wr_en, reg_wr_addr, reg_wr_data,
        output mem_wr_en, mem_wr_addr, mem_wr_data
    );

endinterface

// File: rtl/sprite_cmd_decoder.sv
// Combinational field extraction and opcode legality for one command word.
module sprite_cmd_decoder
    import sprite_gpu_pkg::*;
(
    input  logic [CMD_W-1:0] i_cmd_word,
    output cmd_fields_t      o_fields
);

    logic [OPCODE_W-1:0] w_opcode;
    logic                w_unused;

    assign w_opcode = i_cmd_word[CMD_OP_LSB +: OPCODE_W];
    assign w_unused = ^i_cmd_word[CMD_W-1:CMD_USED_W];

    always_comb begin
        o_fields          = '0;
        o_fields.reg_idx  = i_cmd_word[CMD_IDX_LSB   +: REG_ADDR_W];
        o_fields.sp       = i_cmd_word[CMD_SP_BIT];
        o_fields.x        = i_cmd_word[CMD_X_LSB     +: X_W];
        o_fields.y        = i_cmd_word[CMD_Y_LSB     +: Y_W];
        o_fields.offset   = i_cmd_word[CMD_OFF_LSB   +: OFFSET_W];
        o_fields.mem_addr = i_cmd_word[CMD_ADDR_LSB  +: MEM_ADDR_W];
        o_fields.color    = i_cmd_word[CMD_COLOR_LSB +: COLOR_W];
        case (w_opcode)
            OP_WBR:  o_fields.kind = KIND_WBR;
            OP_WSM:  o_fields.kind = KIND_WSM;
            default: o_fields.kind = KIND_BAD;
        endcase
    end

endmodule

// File: rtl/sprite_write_controller.sv
// Accepts sprite command words and drives the register-bank and sprite-memory write ports.
// Register-bank writes wait for vertical blanking; sprite-memory writes go out immediately.
module sprite_write_controller
    import sprite_gpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    sprite_write_controller_if.slave  bus,
    input  logic                      vblank,
    output logic                      busy,
    output logic                      bad_opcode
);

    state_t                  r_state;
    state_t                  w_next;
    cmd_fields_t             w_dec;
    cmd_fields_t             r_hold;
    logic                    w_accept;
    logic                    r_busy;
    logic                    r_bad;
    logic                    r_reg_wr_en;
    logic [REG_ADDR_W-1:0]   r_reg_wr_addr;
    logic [REG_DATA_W-1:0]   r_reg_wr_data;
    logic                    r_mem_wr_en;
    logic [MEM_ADDR_W-1:0]   r_mem_wr_addr;
    logic [COLOR_W-1:0]      r_mem_wr_data;

    sprite_cmd_decoder u_decoder (
        .i_cmd_word (bus.cmd_word),
        .o_fields   (w_dec)
    );

    assign bus.cmd_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_accept) w_next = ST_DECODE;
            ST_DECODE: begin
                case (r_hold.kind)
                    KIND_WBR: w_next = vblank ? ST_WRITE_REG : ST_WAIT_BLANK;
                    KIND_WSM: w_next = ST_WRITE_MEM;
                    default:  w_next = ST_IDLE;
                endcase
            end
            ST_WAIT_BLANK: if (vblank) w_next = ST_WRITE_REG;
            ST_WRITE_REG:  w_next = ST_IDLE;
            ST_WRITE_MEM:  w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    // Decoded word is held for the whole transaction; a reset simply abandons it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_hold <= '0;
        else if (w_accept) r_hold <= w_dec;
    end

    // Outputs are loaded from the next state so each strobe coincides with its write state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy        <= 1'b0;
            r_bad         <= 1'b0;
            r_reg_wr_en   <= 1'b0;
            r_reg_wr_addr <= '0;
            r_reg_wr_data <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
        end else begin
            r_busy      <= (w_next != ST_IDLE);
            r_bad       <= w_accept && (w_dec.kind == KIND_BAD);
            r_reg_wr_en <= (w_next == ST_WRITE_REG);
            r_mem_wr_en <= (w_next == ST_WRITE_MEM);
            if (w_next == ST_WRITE_REG) begin
                r_reg_wr_addr <= r_hold.reg_idx;
                r_reg_wr_data <= pack_reg_data(r_hold);
            end
            if (w_next == ST_WRITE_MEM) begin
                r_mem_wr_addr <= r_hold.mem_addr;
                r_mem_wr_data <= r_hold.color;
            end
        end
    end

    assign busy            = r_busy;
    assign bad_opcode      = r_bad;
    assign bus.reg_wr_en   = r_reg_wr_en;
    assign bus.reg_wr_addr = r_reg_wr_addr;
    assign bus.reg_wr_data = r_reg_wr_data;
    assign bus.mem_wr_en   = r_mem_wr_en;
    assign bus.mem_wr_addr = r_mem_wr_addr;
    assign bus.mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_sprite_write_controller.sv
// Directed self-checking bench for sprite_write_controller.
module tb_sprite_write_controller;
    import sprite_gpu_pkg::*;

    logic clk;
    logic reset;
    logic vblank;
    logic busy;
    logic bad_opcode;

    int n_checks;
    int n_fail;

    sprite_write_controller_if bus ();

    sprite_write_controller dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .vblank     (vblank),
        .busy       (busy),
        .bad_opcode (bad_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] word);
        bus.cmd_valid = 1'b1;
        bus.cmd_word  = word;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_word  = '0;
    endtask

    function automatic logic [63:0] mk_wbr(input int idx, input int sp, input int x,
                                           input int y, input int off);
        logic [63:0] w;
        w        = 64'hFFFF_FF80_0000_0000;
        w[3:0]   = 4'b0000;
        w[8:4]   = 5'(idx);
        w[9]     = 1'(sp);
        w[19:10] = 10'(x);
        w[29:20] = 10'(y);
        w[38:30] = 9'(off);
        return w;
    endfunction

    function automatic logic [63:0] mk_wsm(input int addr, input int color);
        logic [63:0] w;
        w        = '0;
        w[3:0]   = 4'b0001;
        w[17:4]  = 14'(addr);
        w[26:18] = 9'(color);
        return w;
    endfunction

    initial begin
        logic [63:0] words [3];
        int          wr_kind [8];
        int          wr_addr [8];
        int          wr_data [8];
        int          wr_cyc  [8];
        int          n_wr;
        int          both;
        int          strobes;
        int          busy_low;
        int          idx;
        logic        prev_ready;

        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        vblank        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_word  = '0;
        step();
        step();
        check("ready_in_reset", 64'(bus.cmd_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_ready",    64'(bus.cmd_ready),   64'd1);
        check("rst_busy",     64'(busy),            64'd0);
        check("rst_reg_en",   64'(bus.reg_wr_en),   64'd0);
        check("rst_mem_en",   64'(bus.mem_wr_en),   64'd0);
        check("rst_bad",      64'(bad_opcode),      64'd0);
        check("rst_reg_addr", 64'(bus.reg_wr_addr), 64'd0);
        check("rst_reg_data", 64'(bus.reg_wr_data), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_wr_addr), 64'd0);
        check("rst_mem_data", 64'(bus.mem_wr_data), 64'd0);
        step();

        // WSM: strobe at N+2, ready back at N+3
        send(mk_wsm(100, 9'h1FF));
        check("wsm_n1_ready",  64'(bus.cmd_ready), 64'd0);
        check("wsm_n1_busy",   64'(busy),          64'd1);
        check("wsm_n1_mem_en", 64'(bus.mem_wr_en), 64'd0);
        step();
        check("wsm_n2_mem_en", 64'(bus.mem_wr_en),   64'd1);
        check("wsm_n2_addr",   64'(bus.mem_wr_addr), 64'd100);
        check("wsm_n2_data",   64'(bus.mem_wr_data), 64'h1FF);
        check("wsm_n2_reg_en", 64'(bus.reg_wr_en),   64'd0);
        check("wsm_n2_ready",  64'(bus.cmd_ready),   64'd0);
        step();
        check("wsm_n3_mem_en", 64'(bus.mem_wr_en),   64'd0);
        check("wsm_n3_ready",  64'(bus.cmd_ready),   64'd1);
        check("wsm_n3_busy",   64'(busy),            64'd0);
        check("wsm_n3_hold",   64'(bus.mem_wr_data), 64'h1FF);

        // WBR during blanking: {2'b0,1,320,240,5} = 0x2A01_E005
        vblank = 1'b1;
        send(mk_wbr(3, 1, 320, 240, 5));
        check("wbr_n1_reg_en", 64'(bus.reg_wr_en), 64'd0);
        step();
        check("wbr_n2_reg_en", 64'(bus.reg_wr_en),   64'd1);
        check("wbr_n2_addr",   64'(bus.reg_wr_addr), 64'd3);
        check("wbr_n2_data",   64'(bus.reg_wr_data), 64'h2A01_E005);
        check("wbr_n2_mem_en", 64'(bus.mem_wr_en),   64'd0);
        step();
        check("wbr_n3_reg_en", 64'(bus.reg_wr_en), 64'd0);
        check("wbr_n3_ready",  64'(bus.cmd_ready), 64'd1);
        vblank = 1'b0;

        // WBR outside blanking: {2'b0,0,1023,0,511} = 0x1FF8_01FF
        send(mk_wbr(12, 0, 1023, 0, 511));
        strobes  = 0;
        busy_low = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.reg_wr_en) strobes++;
            if (!busy) busy_low++;
            step();
        end
        check("wait_no_strobe", 64'(strobes),  64'd0);
        check("wait_busy",      64'(busy_low), 64'd0);
        check("wait_ready_low", 64'(bus.cmd_ready), 64'd0);
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        check("wait_strobe", 64'(bus.reg_wr_en),   64'd1);
        check("wait_addr",   64'(bus.reg_wr_addr), 64'd12);
        check("wait_data",   64'(bus.reg_wr_data), 64'h1FF8_01FF);
        step();
        check("wait_done_en",    64'(bus.reg_wr_en),   64'd0);
        check("wait_done_ready", 64'(bus.cmd_ready),   64'd1);
        check("wait_hold_data",  64'(bus.reg_wr_data), 64'h1FF8_01FF);
        check("wait_mem_hold",   64'(bus.mem_wr_addr), 64'd100);

        // Illegal opcode
        send(64'h0000_0000_0000_000F);
        check("bad_n1_pulse",  64'(bad_opcode), 64'd1);
        check("bad_n1_ready",  64'(bus.cmd_ready), 64'd0);
        check("bad_n1_strobe", 64'(bus.reg_wr_en | bus.mem_wr_en), 64'd0);
        step();
        check("bad_n2_pulse",  64'(bad_opcode), 64'd0);
        check("bad_n2_ready",  64'(bus.cmd_ready), 64'd1);
        check("bad_n2_busy",   64'(busy), 64'd0);
        check("bad_n2_strobe", 64'(bus.reg_wr_en | bus.mem_wr_en), 64'd0);

        // Reset while a WBR waits for blanking
        send(mk_wbr(7, 1, 5, 6, 7));
        step();
        step();
        check("rstmid_busy_before", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_busy_in_reset", 64'(busy), 64'd0);
        step();
        reset  = 1'b0;
        vblank = 1'b1;
        #1;
        check("rstmid_ready", 64'(bus.cmd_ready), 64'd1);
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.reg_wr_en) strobes++;
        end
        check("rstmid_no_write", 64'(strobes),         64'd0);
        check("rstmid_addr",     64'(bus.reg_wr_addr), 64'd0);
        check("rstmid_busy",     64'(busy),            64'd0);

        // Back-to-back WSM, WBR, WSM with valid held high
        words[0] = mk_wsm(200, 9'h0AA);
        words[1] = mk_wbr(9, 0, 1, 2, 3);
        words[2] = mk_wsm(300, 9'h155);
        n_wr = 0;
        both = 0;
        idx  = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_word  = words[0];
        for (int c = 0; c < 15; c++) begin
            prev_ready = bus.cmd_ready;
            step();
            if (bus.reg_wr_en && bus.mem_wr_en) both++;
            if ((bus.reg_wr_en || bus.mem_wr_en) && n_wr < 8) begin
                wr_kind[n_wr] = bus.reg_wr_en ? 1 : 0;
                wr_addr[n_wr] = bus.reg_wr_en ? int'(bus.reg_wr_addr) : int'(bus.mem_wr_addr);
                wr_data[n_wr] = bus.reg_wr_en ? int'(bus.reg_wr_data) : int'(bus.mem_wr_data);
                wr_cyc[n_wr]  = c;
                n_wr++;
            end
            if (prev_ready && bus.cmd_valid) begin
                idx++;
                if (idx < 3) bus.cmd_word = words[idx];
                else begin
                    bus.cmd_valid = 1'b0;
                    bus.cmd_word  = '0;
                end
            end
        end
        bus.cmd_valid = 1'b0;
        vblank        = 1'b0;
        check("b2b_accepted", 64'(idx),  64'd3);
        check("b2b_writes",   64'(n_wr), 64'd3);
        check("b2b_overlap",  64'(both), 64'd0);
        if (n_wr >= 3) begin
            check("b2b_w0_kind", 64'(wr_kind[0]), 64'd0);
            check("b2b_w0_addr", 64'(wr_addr[0]), 64'd200);
            check("b2b_w0_data", 64'(wr_data[0]), 64'h0AA);
            check("b2b_w1_kind", 64'(wr_kind[1]), 64'd1);
            check("b2b_w1_addr", 64'(wr_addr[1]), 64'd9);
            check("b2b_w1_data", 64'(wr_data[1]), 64'h0008_0403);
            check("b2b_w2_kind", 64'(wr_kind[2]), 64'd0);
            check("b2b_w2_addr", 64'(wr_addr[2]), 64'd300);
            check("b2b_w2_data", 64'(wr_data[2]), 64'h155);
            check("b2b_gap01",   64'(wr_cyc[1] - wr_cyc[0]), 64'd3);
            check("b2b_gap12",   64'(wr_cyc[2] - wr_cyc[1]), 64'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
